// File: rtl/core_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  core_ctrl_pkg
//  Shared control-path types: issue FSM states, register index, RV32I opcodes.
//  Rev 1.0 - initial release
// ============================================================================
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef logic [4:0] reg_idx_t;

    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;

    function automatic logic f_uses_rs1(input logic [6:0] opcode);
        f_uses_rs1 = (opcode == c_OPC_JALR)   || (opcode == c_OPC_LOAD)  ||
                     (opcode == c_OPC_OP_IMM) || (opcode == c_OPC_OP)    ||
                     (opcode == c_OPC_STORE)  || (opcode == c_OPC_BRANCH);
    endfunction

    function automatic logic f_uses_rs2(input logic [6:0] opcode);
        f_uses_rs2 = (opcode == c_OPC_OP) || (opcode == c_OPC_STORE) ||
                     (opcode == c_OPC_BRANCH);
    endfunction

    // Opcode-only check; the caller still has to exclude rd == x0.
    function automatic logic f_writes_rd(input logic [6:0] opcode);
        f_writes_rd = (opcode == c_OPC_LUI)    || (opcode == c_OPC_AUIPC) ||
                      (opcode == c_OPC_JAL)    || (opcode == c_OPC_JALR)  ||
                      (opcode == c_OPC_LOAD)   || (opcode == c_OPC_OP_IMM) ||
                      (opcode == c_OPC_OP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/define.sv
`default_nettype none
// ============================================================================
//  define.sv
//  Global core macros shared by the control path.
//  Rev 1.0 - initial release
// ============================================================================
`ifndef CORE_DEFINE_SV
`define CORE_DEFINE_SV
`define XLEN 32
`endif
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  hazard_scoreboard
//  Busy bit per architectural register with set/clear and two read lookups.
//  Rev 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import core_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_set_en,
    input  reg_idx_t i_set_rd,
    input  logic     i_clr_en,
    input  reg_idx_t i_clr_rd,
    input  reg_idx_t i_rs1,
    input  reg_idx_t i_rs2,
    output logic     o_rs1_busy,
    output logic     o_rs2_busy
);

    logic [31:0] r_busy;
    logic [31:0] w_busy_nxt;

    // x0 is hard-wired idle, so lookups of x0 can never report a hazard.
    assign w_busy_nxt[0] = 1'b0;

    // A new writer issuing in the same cycle as a retiring write wins.
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy_bit
        assign w_busy_nxt[gi] = (i_set_en && (i_set_rd == 5'(gi))) ||
                                (r_busy[gi] && !(i_clr_en && (i_clr_rd == 5'(gi))));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_rs1_busy = r_busy[i_rs1];
    assign o_rs2_busy = r_busy[i_rs2];

endmodule
`default_nettype wire

// File: rtl/pipe_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  pipe_issue_ctrl
//  In-order issue control: RAW stall via scoreboard, redirect bubble insertion.
//  Rev 1.0 - initial release
// ============================================================================
`ifndef XLEN
`define XLEN 32
`endif
module pipe_issue_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   instr_valid,
    input  logic [`XLEN-1:0]       instruction_in,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_rd,
    input  logic                   flush_req,
    output logic                   halt,
    output logic                   issue_valid,
    output logic                   flush,
    output logic [1:0]             state_out,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] c_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t                 r_state;
    logic [3:0]             r_bubble_cnt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic [6:0] w_opcode;
    reg_idx_t   w_rs1;
    reg_idx_t   w_rs2;
    reg_idx_t   w_rd;
    logic       w_use_rs1;
    logic       w_use_rs2;
    logic       w_writes_rd;
    logic       w_rs1_busy;
    logic       w_rs2_busy;
    logic       w_hazard;
    logic       w_in_flush;
    logic       w_unused_instr;

    assign w_opcode       = instruction_in[6:0];
    assign w_rd           = instruction_in[11:7];
    assign w_rs1          = instruction_in[19:15];
    assign w_rs2          = instruction_in[24:20];
    assign w_unused_instr = ^{instruction_in[`XLEN-1:25], instruction_in[14:12]};

    assign w_use_rs1   = f_uses_rs1(w_opcode);
    assign w_use_rs2   = f_uses_rs2(w_opcode);
    assign w_writes_rd = f_writes_rd(w_opcode) && (w_rd != 5'd0);

    hazard_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set_en   (issue_valid && w_writes_rd),
        .i_set_rd   (w_rd),
        .i_clr_en   (wb_valid),
        .i_clr_rd   (wb_rd),
        .i_rs1      (w_rs1),
        .i_rs2      (w_rs2),
        .o_rs1_busy (w_rs1_busy),
        .o_rs2_busy (w_rs2_busy)
    );

    assign w_hazard   = instr_valid && ((w_use_rs1 && w_rs1_busy) || (w_use_rs2 && w_rs2_busy));
    assign w_in_flush = (r_state == ST_FLUSH);

    // A pending redirect means the next state is FLUSH, which suppresses halt.
    assign halt        = rst_n && w_hazard && !flush_req && !w_in_flush;
    assign issue_valid = rst_n && instr_valid && !w_hazard && !flush_req && !w_in_flush;
    assign flush       = rst_n && (flush_req || w_in_flush);
    assign state_out   = r_state;
    assign stall_cnt   = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_bubble_cnt <= 4'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (flush_req) begin
                        r_state      <= ST_FLUSH;
                        r_bubble_cnt <= c_FLUSH_LOAD;
                    end else if (w_hazard) begin
                        r_state <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (flush_req) begin
                        r_state      <= ST_FLUSH;
                        r_bubble_cnt <= c_FLUSH_LOAD;
                    end else if (!w_hazard) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    // A redirect arriving mid-flush restarts the bubble window.
                    if (flush_req) begin
                        r_bubble_cnt <= c_FLUSH_LOAD;
                    end else if (r_bubble_cnt == 4'd0) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_bubble_cnt <= r_bubble_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state      <= ST_RUN;
                    r_bubble_cnt <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (halt && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire
